// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the 5-stage core's hazard and forwarding logic.
package riscv_pipe_pkg;

  // Forwarding mux selects driven into the E-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Next-PC source selected by the instruction in E
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  // x0 is hardwired to zero and is never a forwarding or load-use source
  localparam int unsigned X0_IDX = 0;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  // M stage holds the younger result, so it takes priority over W
  function automatic logic [1:0] fwd_pick(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority; increment only while below the saturation value
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: operand forwarding, load-use stall, branch flush,
// multi-cycle execute occupancy and stall/flush performance counters.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              LoadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        PCSrcE,
  input  logic              McStartE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic              McFirst,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  // Down-counter only has to hold MC_LAT-2; keep at least one bit
  localparam int unsigned DCW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam bit          MC_EN = (MC_LAT > 1);
  localparam logic [DCW-1:0] CNT_LOAD = DCW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
  localparam logic [REG_AW-1:0] X0 = REG_AW'(X0_IDX);

  mc_state_e        r_state;
  mc_state_e        w_state_nxt;
  logic [DCW-1:0]   r_cnt;
  logic [DCW-1:0]   w_cnt_nxt;
  logic             w_mc_stall;
  logic             w_mc_first;
  logic             w_lw_stall;
  logic             w_br_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Per-operand forwarding select plus load-use and branch hazard detection
  always_comb begin
    w_fwd_a = fwd_pick(RegWriteM && (RdM != X0) && (RdM == Rs1E),
                       RegWriteW && (RdW != X0) && (RdW == Rs1E));
    w_fwd_b = fwd_pick(RegWriteM && (RdM != X0) && (RdM == Rs2E),
                       RegWriteW && (RdW != X0) && (RdW == Rs2E));
    w_lw_stall = LoadE && (RdE != X0) && ((RdE == Rs1D) || (RdE == Rs2D));
    w_br_flush = (PCSrcE != PCSRC_SEQ);
  end

  // Multi-cycle occupancy: next state, down-counter load/decrement, stall and strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    w_mc_first  = 1'b0;
    unique case (r_state)
      MC_IDLE: begin
        if (McStartE && MC_EN) begin
          w_mc_stall = 1'b1;
          // A start coinciding with a redirect is ignored by the FSM
          if (!w_br_flush) begin
            w_state_nxt = MC_BUSY;
            w_cnt_nxt   = CNT_LOAD;
            w_mc_first  = 1'b1;
          end
        end
      end
      MC_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = MC_IDLE;
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_mc_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = MC_IDLE;
      end
    endcase
  end

  // FSM state and down-counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= MC_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign StallF    = w_lw_stall || w_mc_stall;
  assign StallD    = w_lw_stall || w_mc_stall;
  assign StallE    = w_mc_stall;
  assign FlushM    = w_mc_stall;
  assign FlushD    = w_br_flush;
  // A held ID-EX register must keep its multi-cycle op, so it is never bubbled
  assign FlushE    = (w_lw_stall || w_br_flush) && !w_mc_stall;
  assign ForwardAE = w_fwd_a;
  assign ForwardBE = w_fwd_b;
  assign McBusy    = (r_state == MC_BUSY);
  assign McFirst   = w_mc_first;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (CLK),
    .i_clr_n (RST_N),
    .i_inc   (StallD),
    .o_cnt   (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (CLK),
    .i_clr_n (RST_N),
    .i_inc   (FlushD),
    .o_cnt   (FlushCnt)
  );

  // A multi-cycle op must never be in E together with a control-flow redirect
  a_no_mc_redirect: assert property (@(posedge CLK) disable iff (!RST_N)
    !(McStartE && (PCSrcE != PCSRC_SEQ)));

endmodule
